// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: producer channels in, regfile write ports out.
// master = execution-unit / regfile side, slave = the arbiter.
interface wb_arbiter_if #(
   parameter int NUM_FU    = 4,
   parameter int NUM_WB    = 2,
   parameter int WORD_W    = 64,
   parameter int PREG_W    = 7,
   parameter int ROB_PTR_W = 5
);
   localparam int FU_ID_W = $clog2(NUM_FU);

   logic [NUM_FU-1:0]           fu_valid_in;
   logic [NUM_FU-1:0]           fu_ready_out;
   logic [NUM_FU*PREG_W-1:0]    fu_preg_in;
   logic [NUM_FU*WORD_W-1:0]    fu_data_in;
   logic [NUM_FU*ROB_PTR_W-1:0] fu_rob_ptr_in;

   logic [NUM_WB-1:0]           wb_valid_out;
   logic [NUM_WB*PREG_W-1:0]    wb_preg_out;
   logic [NUM_WB*WORD_W-1:0]    wb_data_out;
   logic [NUM_WB*ROB_PTR_W-1:0] wb_rob_ptr_out;
   logic [NUM_WB*FU_ID_W-1:0]   wb_fu_id_out;

   modport master (
      output fu_valid_in, fu_preg_in, fu_data_in, fu_rob_ptr_in,
      input  fu_ready_out,
      input  wb_valid_out, wb_preg_out, wb_data_out, wb_rob_ptr_out, wb_fu_id_out
   );

   modport slave (
      input  fu_valid_in, fu_preg_in, fu_data_in, fu_rob_ptr_in,
      output fu_ready_out,
      output wb_valid_out, wb_preg_out, wb_data_out, wb_rob_ptr_out, wb_fu_id_out
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NUM_FU producer channels, each behind a FIFO, share
// NUM_WB regfile write ports granted round-robin. A grant is a pop; the
// regfile never backpressures.
// Optional macro WB_ARB_BYPASS_EN: an empty channel with valid input may be
// granted in the same cycle straight from its input payload.
module wb_arbiter #(
   parameter int NUM_FU     = 4,
   parameter int NUM_WB     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int WORD_W     = 64,
   parameter int PREG_W     = 7,
   parameter int ROB_PTR_W  = 5
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        flush_in,
   wb_arbiter_if.slave bus
);
   localparam int FU_ID_W = $clog2(NUM_FU);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int NG_W    = $clog2(NUM_WB + 1);

   // FIFO storage (payload only, never reset) and FIFO control state
   logic [PREG_W-1:0]    r_preg [NUM_FU][FIFO_DEPTH];
   logic [WORD_W-1:0]    r_data [NUM_FU][FIFO_DEPTH];
   logic [ROB_PTR_W-1:0] r_rob  [NUM_FU][FIFO_DEPTH];
   logic [PTR_W-1:0]     r_rd_ptr [NUM_FU];
   logic [PTR_W-1:0]     r_wr_ptr [NUM_FU];
   logic [CNT_W-1:0]     r_count  [NUM_FU];
   logic [FU_ID_W-1:0]   r_rr_ptr;

   // Unpacked views of the inputs and of each channel's candidate payload
   logic [PREG_W-1:0]    w_in_preg [NUM_FU];
   logic [WORD_W-1:0]    w_in_data [NUM_FU];
   logic [ROB_PTR_W-1:0] w_in_rob  [NUM_FU];
   logic [PREG_W-1:0]    w_hd_preg [NUM_FU];
   logic [WORD_W-1:0]    w_hd_data [NUM_FU];
   logic [ROB_PTR_W-1:0] w_hd_rob  [NUM_FU];

   logic [NUM_FU-1:0]    w_empty;
   logic [NUM_FU-1:0]    w_ready;
   logic [NUM_FU-1:0]    w_byp;
   logic [NUM_FU-1:0]    w_elig;
   logic [NUM_FU-1:0]    w_grant;
   logic [NUM_FU-1:0]    w_push;
   logic [NUM_FU-1:0]    w_pop;
   logic [FU_ID_W-1:0]   w_sel [NUM_WB];
   logic [NG_W-1:0]      w_ngrant;
   logic [FU_ID_W-1:0]   w_next_rr;

   // Per-channel status, eligibility and the payload each channel would present
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         w_in_preg[i] = bus.fu_preg_in[i*PREG_W +: PREG_W];
         w_in_data[i] = bus.fu_data_in[i*WORD_W +: WORD_W];
         w_in_rob[i]  = bus.fu_rob_ptr_in[i*ROB_PTR_W +: ROB_PTR_W];
         w_empty[i]   = (r_count[i] == '0);
         // Ready looks only at registered occupancy; a pop this cycle does not
         // open the FIFO until the next one.
         w_ready[i]   = ~rst_in & (r_count[i] < CNT_W'(FIFO_DEPTH));
`ifdef WB_ARB_BYPASS_EN
         w_byp[i]     = w_empty[i] & bus.fu_valid_in[i] & ~flush_in & ~rst_in;
`else
         w_byp[i]     = 1'b0;
`endif
         w_elig[i]    = ~flush_in & (~w_empty[i] | w_byp[i]);
         w_hd_preg[i] = w_byp[i] ? w_in_preg[i] : r_preg[i][r_rd_ptr[i]];
         w_hd_data[i] = w_byp[i] ? w_in_data[i] : r_data[i][r_rd_ptr[i]];
         w_hd_rob[i]  = w_byp[i] ? w_in_rob[i]  : r_rob[i][r_rd_ptr[i]];
      end
   end

   // Round-robin scan from r_rr_ptr: first NUM_WB eligible channels win,
   // the j-th winner in scan order drives port j
   always_comb begin
      int                 v_pos;
      logic [FU_ID_W-1:0] v_idx;
      logic [NG_W-1:0]    v_n;
      v_pos     = 0;
      v_idx     = '0;
      v_n       = '0;
      w_grant   = '0;
      w_next_rr = r_rr_ptr;
      for (int j = 0; j < NUM_WB; j++) begin
         w_sel[j] = '0;
      end
      for (int k = 0; k < NUM_FU; k++) begin
         v_pos = int'(r_rr_ptr) + k;
         if (v_pos >= NUM_FU) begin
            v_pos = v_pos - NUM_FU;
         end
         v_idx = FU_ID_W'(v_pos);
         if (w_elig[v_idx] && (v_n < NG_W'(NUM_WB))) begin
            w_grant[v_idx] = 1'b1;
            for (int j = 0; j < NUM_WB; j++) begin
               if (NG_W'(j) == v_n) begin
                  w_sel[j] = v_idx;
               end
            end
            v_n       = v_n + NG_W'(1);
            w_next_rr = (v_pos == NUM_FU - 1) ? '0 : FU_ID_W'(v_pos + 1);
         end
      end
      w_ngrant = v_n;
   end

   // Push/pop decisions: a bypassed grant is consumed without touching the FIFO
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         w_pop[i]  = w_grant[i] & ~w_byp[i];
         w_push[i] = bus.fu_valid_in[i] & w_ready[i] & ~flush_in
                     & ~(w_grant[i] & w_byp[i]);
      end
   end

   // Drive write ports from the selected channel heads
   always_comb begin
      for (int j = 0; j < NUM_WB; j++) begin
         bus.wb_valid_out[j]                          = (NG_W'(j) < w_ngrant);
         bus.wb_preg_out[j*PREG_W +: PREG_W]          = w_hd_preg[w_sel[j]];
         bus.wb_data_out[j*WORD_W +: WORD_W]          = w_hd_data[w_sel[j]];
         bus.wb_rob_ptr_out[j*ROB_PTR_W +: ROB_PTR_W] = w_hd_rob[w_sel[j]];
         bus.wb_fu_id_out[j*FU_ID_W +: FU_ID_W]       = w_sel[j];
      end
   end

   assign bus.fu_ready_out = w_ready;

   // FIFO pointers, occupancy and round-robin pointer; flush beats push/pop
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_FU; i++) begin
            r_rd_ptr[i] <= '0;
            r_wr_ptr[i] <= '0;
            r_count[i]  <= '0;
         end
         r_rr_ptr <= '0;
      end else if (flush_in) begin
         for (int i = 0; i < NUM_FU; i++) begin
            r_rd_ptr[i] <= '0;
            r_wr_ptr[i] <= '0;
            r_count[i]  <= '0;
         end
         r_rr_ptr <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (w_push[i]) begin
               r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
            end
            if (w_pop[i]) begin
               r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
            end
            r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
         end
         if (w_ngrant != '0) begin
            r_rr_ptr <= w_next_rr;
         end
      end
   end

   // FIFO payload write at the tail slot
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (w_push[i]) begin
            r_preg[i][r_wr_ptr[i]] <= w_in_preg[i];
            r_data[i][r_wr_ptr[i]] <= w_in_data[i];
            r_rob[i][r_wr_ptr[i]]  <= w_in_rob[i];
         end
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (default NUM_FU=4, NUM_WB=2, depth 4).
// Inputs change 1 ns after the rising edge; outputs are checked either right
// after that or on the falling edge.
`timescale 1ns/1ps
module tb_wb_arbiter;
   localparam int NUM_FU     = 4;
   localparam int NUM_WB     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int WORD_W     = 64;
   localparam int PREG_W     = 7;
   localparam int ROB_PTR_W  = 5;
   localparam int FU_ID_W    = 2;

   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   errors;

   wb_arbiter_if #(.NUM_FU(NUM_FU), .NUM_WB(NUM_WB), .WORD_W(WORD_W),
                   .PREG_W(PREG_W), .ROB_PTR_W(ROB_PTR_W)) bus ();

   wb_arbiter #(.NUM_FU(NUM_FU), .NUM_WB(NUM_WB), .FIFO_DEPTH(FIFO_DEPTH),
                .WORD_W(WORD_W), .PREG_W(PREG_W), .ROB_PTR_W(ROB_PTR_W)) dut (
      .clk_in   (clk),
      .rst_in   (rst),
      .flush_in (flush),
      .bus      (bus)
   );

   logic [PREG_W-1:0]    p0_preg, p1_preg;
   logic [WORD_W-1:0]    p0_data;
   logic [ROB_PTR_W-1:0] p0_rob;
   logic [FU_ID_W-1:0]   p0_id, p1_id;
   assign p0_preg = bus.wb_preg_out[0 +: PREG_W];
   assign p1_preg = bus.wb_preg_out[PREG_W +: PREG_W];
   assign p0_data = bus.wb_data_out[0 +: WORD_W];
   assign p0_rob  = bus.wb_rob_ptr_out[0 +: ROB_PTR_W];
   assign p0_id   = bus.wb_fu_id_out[0 +: FU_ID_W];
   assign p1_id   = bus.wb_fu_id_out[FU_ID_W +: FU_ID_W];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [PREG_W-1:0] p,
                         input logic [WORD_W-1:0] d, input logic [ROB_PTR_W-1:0] r);
      bus.fu_preg_in[i*PREG_W +: PREG_W]          = p;
      bus.fu_data_in[i*WORD_W +: WORD_W]          = d;
      bus.fu_rob_ptr_in[i*ROB_PTR_W +: ROB_PTR_W] = r;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (bus.fu_ready_out !== 4'b0000) begin errors++;
         $display("FAIL reset_ready act=%b exp=%b", bus.fu_ready_out, 4'b0000); end
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL reset_valid act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      @(posedge clk); #1 rst = 1'b0;
      #1;
      checks++; if (bus.fu_ready_out !== 4'b1111) begin errors++;
         $display("FAIL release_ready act=%b exp=%b", bus.fu_ready_out, 4'b1111); end
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL release_valid act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      // Buffer traffic, then reset while it is on the ports
      tick();
      set_ch(0, 7'd1, 64'h11, 5'd1);
      set_ch(1, 7'd2, 64'h22, 5'd2);
      bus.fu_valid_in = 4'b0011;
      tick();
      bus.fu_valid_in = 4'b0000;
`ifndef WB_ARB_BYPASS_EN
      checks++; if (bus.wb_valid_out !== 2'b11) begin errors++;
         $display("FAIL midtraffic_valid act=%b exp=%b", bus.wb_valid_out, 2'b11); end
`endif
      rst = 1'b1;
      #1;
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL midrst_valid act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      checks++; if (bus.fu_ready_out !== 4'b0000) begin errors++;
         $display("FAIL midrst_ready act=%b exp=%b", bus.fu_ready_out, 4'b0000); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.fu_ready_out !== 4'b1111) begin errors++;
         $display("FAIL postrst_ready act=%b exp=%b", bus.fu_ready_out, 4'b1111); end
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL postrst_stale act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      tick();
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL postrst_stale2 act=%b exp=%b", bus.wb_valid_out, 2'b00); end
   endtask

   task automatic test_single();
      set_ch(2, 7'd9, 64'hDEAD, 5'd3);
      bus.fu_valid_in = 4'b0100;
      #1;
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL single_sameCycle act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      tick();
      bus.fu_valid_in = 4'b0000;
      checks++; if (bus.wb_valid_out !== 2'b01) begin errors++;
         $display("FAIL single_valid act=%b exp=%b", bus.wb_valid_out, 2'b01); end
      checks++; if (p0_preg !== 7'd9) begin errors++;
         $display("FAIL single_preg act=%0d exp=%0d", p0_preg, 9); end
      checks++; if (p0_data !== 64'hDEAD) begin errors++;
         $display("FAIL single_data act=%h exp=%h", p0_data, 64'hDEAD); end
      checks++; if (p0_rob !== 5'd3) begin errors++;
         $display("FAIL single_rob act=%0d exp=%0d", p0_rob, 3); end
      checks++; if (p0_id !== 2'd2) begin errors++;
         $display("FAIL single_fuid act=%0d exp=%0d", p0_id, 2); end
      tick();
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL single_drained act=%b exp=%b", bus.wb_valid_out, 2'b00); end
   endtask

   task automatic test_contention();
      // flush returns the round-robin pointer to channel 0
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < NUM_FU; i++) set_ch(i, 7'(10 + i), 64'(32'hC000 + i), 5'(i));
      bus.fu_valid_in = 4'b1111;
      tick();
      bus.fu_valid_in = 4'b0000;
      checks++; if (bus.wb_valid_out !== 2'b11) begin errors++;
         $display("FAIL cont1_valid act=%b exp=%b", bus.wb_valid_out, 2'b11); end
      checks++; if ({p0_id, p1_id} !== {2'd0, 2'd1}) begin errors++;
         $display("FAIL cont1_ids act=%0d,%0d exp=0,1", p0_id, p1_id); end
      checks++; if ({p0_preg, p1_preg} !== {7'd10, 7'd11}) begin errors++;
         $display("FAIL cont1_preg act=%0d,%0d exp=10,11", p0_preg, p1_preg); end
      tick();
      checks++; if (bus.wb_valid_out !== 2'b11) begin errors++;
         $display("FAIL cont2_valid act=%b exp=%b", bus.wb_valid_out, 2'b11); end
      checks++; if ({p0_id, p1_id} !== {2'd2, 2'd3}) begin errors++;
         $display("FAIL cont2_ids act=%0d,%0d exp=2,3", p0_id, p1_id); end
      checks++; if ({p0_preg, p1_preg} !== {7'd12, 7'd13}) begin errors++;
         $display("FAIL cont2_preg act=%0d,%0d exp=12,13", p0_preg, p1_preg); end
      tick();
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL cont3_valid act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      // rr_ptr back at 0: ch0 must take port 0 ahead of ch3
      set_ch(0, 7'd20, 64'h20, 5'd0);
      set_ch(3, 7'd23, 64'h23, 5'd3);
      bus.fu_valid_in = 4'b1001;
      tick();
      bus.fu_valid_in = 4'b0000;
      checks++; if ({p0_id, p1_id} !== {2'd0, 2'd3}) begin errors++;
         $display("FAIL cont_rr0_ids act=%0d,%0d exp=0,3", p0_id, p1_id); end
      checks++; if ({p0_preg, p1_preg} !== {7'd20, 7'd23}) begin errors++;
         $display("FAIL cont_rr0_preg act=%0d,%0d exp=20,23", p0_preg, p1_preg); end
      tick();
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL cont_end_valid act=%b exp=%b", bus.wb_valid_out, 2'b00); end
   endtask

   // All four channels stream continuously; ports alternate {0,1} and {2,3},
   // so occupancy climbs until FIFOs fill. Expected ready per cycle c0..c8.
   task automatic test_full();
      int          acc [NUM_FU];
      logic [3:0]  rdy;
      logic [35:0] exp_rdy_tab;
      logic [3:0]  exp_rdy;
      exp_rdy_tab = {4'b0011, 4'b1100, 4'b0011, 4'b1111, 4'b1111,
                     4'b1111, 4'b1111, 4'b1111, 4'b1111};
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < NUM_FU; i++) acc[i] = 0;
      bus.fu_valid_in = 4'b1111;
      for (int c = 0; c < 9; c++) begin
         for (int i = 0; i < NUM_FU; i++)
            set_ch(i, 7'(i), 64'(32'hF000 + i*256 + acc[i]), 5'(acc[i]));
         @(negedge clk);
         exp_rdy = exp_rdy_tab[c*4 +: 4];
         checks++; if (bus.fu_ready_out !== exp_rdy) begin errors++;
            $display("FAIL full_ready c%0d act=%b exp=%b", c, bus.fu_ready_out, exp_rdy); end
         checks++; if (bus.wb_valid_out !== ((c == 0) ? 2'b00 : 2'b11)) begin errors++;
            $display("FAIL full_valid c%0d act=%b", c, bus.wb_valid_out); end
         if (c > 0) begin
            checks++;
            if ({p0_id, p1_id} !== (c % 2 == 1 ? {2'd0, 2'd1} : {2'd2, 2'd3})) begin errors++;
               $display("FAIL full_ids c%0d act=%0d,%0d", c, p0_id, p1_id); end
         end
         if (c % 2 == 1) begin
            checks++;
            if (p0_data !== 64'(32'hF000 + (c - 1) / 2)) begin errors++;
               $display("FAIL full_ch0_order c%0d act=%h exp=%h", c, p0_data,
                        64'(32'hF000 + (c - 1) / 2)); end
         end
         rdy = bus.fu_ready_out;
         @(posedge clk);
         for (int i = 0; i < NUM_FU; i++) if (rdy[i]) acc[i]++;
         #1;
      end
      bus.fu_valid_in = 4'b0000;
   endtask

   // Picks up the FIFO contents left by test_full (3-4 entries per channel)
   task automatic test_flush();
      @(negedge clk);
      checks++; if (p0_id !== 2'd0) begin errors++;
         $display("FAIL preflush_id act=%0d exp=0", p0_id); end
      tick();
      checks++; if ({p0_id, p1_id} !== {2'd2, 2'd3}) begin errors++;
         $display("FAIL preflush_ids act=%0d,%0d exp=2,3", p0_id, p1_id); end
      flush = 1'b1;
      set_ch(0, 7'd77, 64'hBAD, 5'd7);
      bus.fu_valid_in = 4'b0001;
      #1;
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL flush_valid act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      tick();
      flush = 1'b0;
      bus.fu_valid_in = 4'b0000;
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL postflush_valid act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      checks++; if (bus.fu_ready_out !== 4'b1111) begin errors++;
         $display("FAIL postflush_ready act=%b exp=%b", bus.fu_ready_out, 4'b1111); end
      // rr_ptr must be 0 again: ch1 ahead of ch3
      set_ch(1, 7'd31, 64'h31, 5'd1);
      set_ch(3, 7'd33, 64'h33, 5'd3);
      bus.fu_valid_in = 4'b1010;
      tick();
      bus.fu_valid_in = 4'b0000;
      checks++; if ({p0_id, p1_id} !== {2'd1, 2'd3}) begin errors++;
         $display("FAIL postflush_rr act=%0d,%0d exp=1,3", p0_id, p1_id); end
      tick();
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL postflush_end act=%b exp=%b", bus.wb_valid_out, 2'b00); end
   endtask

   task automatic test_bypass();
      set_ch(3, 7'd42, 64'hB0B, 5'd6);
      bus.fu_valid_in = 4'b1000;
      #1;
      checks++; if (bus.wb_valid_out !== 2'b01) begin errors++;
         $display("FAIL byp_valid act=%b exp=%b", bus.wb_valid_out, 2'b01); end
      checks++; if (p0_id !== 2'd3) begin errors++;
         $display("FAIL byp_fuid act=%0d exp=3", p0_id); end
      checks++; if ({p0_preg, p0_data} !== {7'd42, 64'hB0B}) begin errors++;
         $display("FAIL byp_payload act=%0d/%h exp=42/b0b", p0_preg, p0_data); end
      tick();
      bus.fu_valid_in = 4'b0000;
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL byp_not_queued act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      checks++; if (bus.fu_ready_out !== 4'b1111) begin errors++;
         $display("FAIL byp_ready act=%b exp=%b", bus.fu_ready_out, 4'b1111); end
      flush = 1'b1;
      bus.fu_valid_in = 4'b1000;
      #1;
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL byp_flush act=%b exp=%b", bus.wb_valid_out, 2'b00); end
      tick();
      flush = 1'b0;
      bus.fu_valid_in = 4'b0000;
      checks++; if (bus.wb_valid_out !== 2'b00) begin errors++;
         $display("FAIL byp_flush_drop act=%b exp=%b", bus.wb_valid_out, 2'b00); end
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      rst               = 1'b1;
      flush             = 1'b0;
      bus.fu_valid_in   = '0;
      bus.fu_preg_in    = '0;
      bus.fu_data_in    = '0;
      bus.fu_rob_ptr_in = '0;
      test_reset();
`ifdef WB_ARB_BYPASS_EN
      test_bypass();
`else
      test_single();
      test_contention();
      test_full();
      test_flush();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
